// File: rtl/left_shift_unit.sv
// left_shift_unit
//   Multi-cycle left shifter: moves a latched operand one bit per clock for a
//   requested number of positions. Logical mode shifts in zeros. Arithmetic
//   mode saturates to the largest magnitude of the original sign on overflow.
//   A start/ready/done handshake accepts one operation at a time.
//
// Ports
//   clk, rst_n  clock, synchronous active-low reset
//   start       request, accepted only while ready=1
//   in          operand, latched on accept
//   amount      shift positions; values above WIDTH are clamped to WIDTH
//   mode        0 = logical, 1 = arithmetic (saturating); latched on accept
//   ready       high in IDLE
//   busy        high while shifting
//   done        one-cycle pulse; out/overflow are final
//   out         working / result register
//   overflow    sticky overflow flag for the current operation
module left_shift_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] amount,
  input  logic             mode,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic [CNT_W-1:0] amt_clamp;
  logic [WIDTH-1:0] step_out;
  logic             step_ovf;

  assign amt_clamp = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;

  // One shift step on the current working value.
  always_comb begin
    step_out = {out[WIDTH-2:0], 1'b0};
    step_ovf = overflow;
    if (!mode_q) begin
      step_ovf = overflow | out[WIDTH-1];
    end else if (overflow) begin
      // Already saturated: hold, but the counter keeps running so latency
      // stays data-independent.
      step_out = out;
    end else if (out[WIDTH-1] != out[WIDTH-2]) begin
      step_ovf = 1'b1;
      step_out = out[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (amt_clamp == '0) ? DONE : SHIFT;
      SHIFT: if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      out      <= '0;
      overflow <= 1'b0;
      cnt      <= '0;
      mode_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          out      <= in;
          mode_q   <= mode;
          cnt      <= amt_clamp;
          overflow <= 1'b0;
        end
        SHIFT: begin
          out      <= step_out;
          overflow <= step_ovf;
          cnt      <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_left_shift_unit.sv
module tb_left_shift_unit;
  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] in = '0;
  logic [CNT_W-1:0] amount = '0;
  logic             mode = 1'b0;
  logic             ready, busy, done, overflow;
  logic [WIDTH-1:0] out;

  left_shift_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in), .amount(amount),
    .mode(mode), .ready(ready), .busy(busy), .done(done), .out(out),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             ovf;
    int               k;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   bcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: count busy cycles, pop and compare on every done pulse.
  always @(negedge clk) begin
    if (!rst_n) bcnt = 0;
    else begin
      if (busy) bcnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out", out, e.out);
          chk("overflow", overflow, e.ovf);
          chk("latency", cyc - e.acc, e.k);
          chk("busy_cycles", bcnt, e.k);
        end
        bcnt = 0;
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] v, input int amt, input logic m,
                       input logic [WIDTH-1:0] eo, input logic ev);
    exp_t e;
    @(negedge clk);
    chk("ready_before_start", ready, 1);
    in = v; amount = CNT_W'(amt); mode = m; start = 1'b1;
    e.out = eo; e.ovf = ev; e.k = (amt > WIDTH) ? WIDTH : amt; e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic run(input logic [WIDTH-1:0] v, input int amt, input logic m,
                     input logic [WIDTH-1:0] eo, input logic ev);
    issue(v, amt, m, eo, ev);
    wait_idle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out", out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Logical
    run(16'h00F1, 4, 1'b0, 16'h0F10, 1'b0);
    run(16'h8001, 1, 1'b0, 16'h0002, 1'b1);
    // Arithmetic
    run(16'hFFF0, 3, 1'b1, 16'hFF80, 1'b0);
    run(16'h4000, 1, 1'b1, 16'h7FFF, 1'b1);
    run(16'hC000, 2, 1'b1, 16'h8000, 1'b1);
    run(16'h2000, 4, 1'b1, 16'h7FFF, 1'b1);  // saturate then hold
    // Boundaries
    run(16'h1234, 0, 1'b0, 16'h1234, 1'b0);
    run(16'h0001, 31, 1'b0, 16'h0000, 1'b1);
    run(16'h0001, 16, 1'b1, 16'h7FFF, 1'b1);

    // Result holds after done
    repeat (3) @(negedge clk);
    chk("hold_out", out, 16'h7FFF);
    chk("hold_ovf", overflow, 1);

    // Start while busy is ignored
    issue(16'h00F1, 4, 1'b0, 16'h0F10, 1'b0);
    chk("busy_mid", busy, 1);
    chk("ready_mid", ready, 0);
    in = 16'hFFFF; amount = CNT_W'(2); mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset mid-shift discards the operation
    issue(16'h0001, 10, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    void'(sb.pop_back());
    chk("midrst_ready", ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_out", out, 0);
    chk("midrst_ovf", overflow, 0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);  // monitor flags any stray done
    chk("post_rst_idle", ready, 1);
    run(16'h0003, 2, 1'b0, 16'h000C, 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
